// File: rtl/des_round_sequencer.sv
// Iterative single-block DES engine: one Feistel round per clock over a shared
// f-function (des_fblock), with IP/FP, PC-1/PC-2 and a rotating C/D key schedule.
// Optional build macro DES_SEQ_DECRYPT_EN: when defined, in_decrypt selects the
// right-rotating (reverse) key schedule; otherwise every block is encrypted.

module des_fblock (
    output logic [31:0] Rout,
    input  logic [31:0] Rin,
    input  logic [47:0] r_key
);
    localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                                12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                                22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    // One entry per S-box, rows 0..3 concatenated, column 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    logic [47:0] mixed;
    logic [31:0] s_out;
    logic [5:0]  sb_in;

    // Expand R, mix in the round key, substitute through the S-boxes, then permute
    always_comb begin
        mixed = '0;
        s_out = '0;
        sb_in = '0;
        Rout  = '0;
        for (int i = 0; i < 48; i++) begin
            mixed[47-i] = Rin[32-E_T[i]] ^ r_key[47-i];
        end
        for (int k = 0; k < 8; k++) begin
            sb_in = mixed[47-6*k -: 6];
            // outer bits pick the row, inner four bits the column
            s_out[31-4*k -: 4] = SBOX[k][255 - 4*int'({sb_in[5], sb_in[0], sb_in[4:1]}) -: 4];
        end
        for (int i = 0; i < 32; i++) begin
            Rout[31-i] = s_out[32-P_T[i]];
        end
    end
endmodule

module des_round_sequencer #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [3:0]  round_idx
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                  10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                  14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                  23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Tables use DES numbering: bit 1 is the MSB of the vector.
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        for (int i = 0; i < 64; i++) perm_ip[63-i] = x[64-IP_T[i]];
    endfunction
    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) perm_fp[63-i] = x[64-FP_T[i]];
    endfunction
    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) perm_pc1[55-i] = x[64-PC1_T[i]];
    endfunction
    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) perm_pc2[47-i] = x[56-PC2_T[i]];
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic [63:0] out_data_q, out_data_d;
    logic [27:0] c_rot, d_rot;
    logic [47:0] round_key;
    logic [31:0] f_out;
    logic        one_shift;

`ifdef DES_SEQ_DECRYPT_EN
    logic dec_q, dec_d;
`else
    logic unused_decrypt;
    assign unused_decrypt = in_decrypt;
`endif

    assign one_shift = (round_q == 4'd0) || (round_q == 4'd1) ||
                       (round_q == 4'd8) || (round_q == 4'd15);

    // Rotate C/D for this round: left by s(j) when encrypting, right by r(j) when decrypting
    always_comb begin
        c_rot = one_shift ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
        d_rot = one_shift ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
`ifdef DES_SEQ_DECRYPT_EN
        if (dec_q) begin
            if (round_q == 4'd0) begin
                c_rot = c_q;
                d_rot = d_q;
            end else if (one_shift) begin
                c_rot = {c_q[0], c_q[27:1]};
                d_rot = {d_q[0], d_q[27:1]};
            end else begin
                c_rot = {c_q[1:0], c_q[27:2]};
                d_rot = {d_q[1:0], d_q[27:2]};
            end
        end
`endif
    end

    assign round_key = perm_pc2({c_rot, d_rot});

    des_fblock u_fblock (
        .Rout  (f_out),
        .Rin   (r_q),
        .r_key (round_key)
    );

    // Block handshake and round sequencing
    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        r_d        = r_q;
        c_d        = c_q;
        d_d        = d_q;
        round_d    = round_q;
        out_data_d = out_data_q;
`ifdef DES_SEQ_DECRYPT_EN
        dec_d      = dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    {l_d, r_d} = perm_ip(in_data);
                    {c_d, d_d} = perm_pc1(in_key);
`ifdef DES_SEQ_DECRYPT_EN
                    dec_d      = in_decrypt;
`endif
                    round_d    = 4'd0;
                    state_d    = S_ROUND;
                end
            end
            S_ROUND: begin
                l_d = r_q;
                r_d = l_q ^ f_out;
                c_d = c_rot;
                d_d = d_rot;
                if (round_q == LAST_ROUND) begin
                    // final swap: preoutput is {R16, L16}
                    out_data_d = perm_fp({l_q ^ f_out, r_q});
                    round_d    = 4'd0;
                    state_d    = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any block in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            round_q    <= '0;
            out_data_q <= '0;
`ifdef DES_SEQ_DECRYPT_EN
            dec_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            r_q        <= r_d;
            c_q        <= c_d;
            d_q        <= d_d;
            round_q    <= round_d;
            out_data_q <= out_data_d;
`ifdef DES_SEQ_DECRYPT_EN
            dec_q      <= dec_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_ROUND) || (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign round_idx = round_q;
endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer using known DES vectors.
module tb_des_round_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [63:0] in_key = '0;
    logic        in_decrypt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy;
    logic [3:0]  round_idx;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] E1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] D2 = 64'h8787878787878787;
    localparam logic [63:0] E2 = 64'h0000000000000000;

    always #5 clk = ~clk;

    des_round_sequencer #(.ROUNDS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block: accept, count latency, optional junk on in_valid, optional backpressure
    task automatic run_block(input string tag, input logic [63:0] key, input logic [63:0] data,
                             input logic dec, input logic [63:0] exp, input bit junk, input int hold);
        int lat;
        in_key     = key;
        in_data    = data;
        in_decrypt = dec;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid   = 1'b0;
        in_data    = {$urandom, $urandom};
        in_key     = ~key;
        in_decrypt = ~dec;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check_eq({tag, "_round_idx"}, 64'(round_idx), 64'(lat - 1));
            if (junk) begin
                in_valid = ~in_valid;
                in_data  = {$urandom, $urandom};
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check_eq({tag, "_latency"}, 64'(lat), 64'd17);
        check_eq({tag, "_out_data"}, out_data, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, "_hold_data"}, out_data, exp);
            check_eq({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        $display("block %s: key=%h data=%h dec=%0d -> out=%h latency=%0d", tag, key, data, dec, exp, lat);
    endtask

    initial begin
        int n;
        int acc_n;
        int res_n;
        int last_acc;
        int ridx;
        bit acc;
        logic [63:0] bk [3];
        logic [63:0] bd [3];
        logic [63:0] be [3];

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_round_idx", 64'(round_idx), 64'd0);

        run_block("enc1", K1, D1, 1'b0, E1, 1'b0, 0);
        run_block("enc2", K2, D2, 1'b0, E2, 1'b0, 0);
`ifdef DES_SEQ_DECRYPT_EN
        run_block("dec1", K1, E1, 1'b1, D1, 1'b0, 0);
`else
        run_block("dec_ignored", K1, D1, 1'b1, E1, 1'b0, 0);
`endif
        // Backpressure with junk traffic during the rounds
        run_block("bp", K1, D1, 1'b0, E1, 1'b1, 10);

        // Reset in the middle of a block
        in_key   = K1;
        in_data  = D1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd7 && n < 30) begin
            tick();
            n++;
        end
        check_eq("mid_reach7", 64'(round_idx), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_busy", 64'(busy), 64'd0);
        check_eq("mid_in_ready", 64'(in_ready), 64'd1);
        check_eq("mid_round_idx", 64'(round_idx), 64'd0);
        $display("block mid_reset: aborted at round 7");
        run_block("after_rst", K1, D1, 1'b0, E1, 1'b0, 0);

        // Back-to-back blocks with in_valid and out_ready held high
        bk[0] = K1; bd[0] = D1; be[0] = E1;
        bk[1] = K2; bd[1] = D2; be[1] = E2;
        bk[2] = K1; bd[2] = D1; be[2] = E1;
        acc_n = 0;
        res_n = 0;
        last_acc = -1;
        ridx = 0;
        in_key     = bk[0];
        in_data    = bd[0];
        in_decrypt = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        for (int c = 0; c < 100 && res_n < 3; c++) begin
            if (busy && !out_valid) begin
                check_eq("b2b_round_idx", 64'(round_idx), 64'(ridx));
                ridx++;
            end
            if (out_valid) begin
                check_eq("b2b_out_data", out_data, be[res_n]);
                $display("block b2b%0d: out=%h", res_n, out_data);
                res_n++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                if (acc_n > 0) check_eq("b2b_spacing", 64'(c - last_acc), 64'd18);
                last_acc = c;
                acc_n++;
                ridx = 0;
            end
            tick();
            if (acc) begin
                if (acc_n < 3) begin
                    in_key  = bk[acc_n];
                    in_data = bd[acc_n];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("b2b_results", 64'(res_n), 64'd3);
        check_eq("b2b_accepts", 64'(acc_n), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
